// File: rtl/sr_reg_bank_pkg.sv
// rtl/sr_reg_bank_pkg.sv - conflict policy encodings and per-bit next-state rule
package sr_reg_bank_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'd0;
    localparam logic [1:0] MODE_SET_DOM = 2'd1;
    localparam logic [1:0] MODE_RST_DOM = 2'd2;
    localparam logic [1:0] MODE_TOGGLE  = 2'd3;

    // Every {s,r,mode} combination maps to a defined bit, so no X can escape.
    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input logic [1:0] mode);
        logic n;
        n = q;
        case ({s, r})
            2'b00: n = q;
            2'b10: n = 1'b1;
            2'b01: n = 1'b0;
            default: begin
                case (mode)
                    MODE_HOLD:    n = q;
                    MODE_SET_DOM: n = 1'b1;
                    MODE_RST_DOM: n = 1'b0;
                    default:      n = ~q;
                endcase
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sr_reg_bank_cell.sv
// rtl/sr_reg_bank_cell.sv - one set/reset channel with edge pulses and sticky conflict flag
module sr_cell
    import sr_reg_bank_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       set,
    input  logic       clr,
    input  logic       ld,
    input  logic       ld_data,
    input  logic       conflict_clr,
    output logic       q,
    output logic       q_rise,
    output logic       q_fall,
    output logic       conflict,
    output logic       conflict_evt
);

    logic q_nxt;

    assign conflict_evt = en & ~ld & set & clr;

    always_comb begin
        q_nxt = q;
        if (ld)
            q_nxt = ld_data;
        else if (en)
            q_nxt = sr_next(q, set, clr, mode);
    end

    // A new conflict outranks a same-edge clear so no event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RESET_BIT;
            q_rise   <= 1'b0;
            q_fall   <= 1'b0;
            conflict <= 1'b0;
        end else begin
            q        <= q_nxt;
            q_rise   <= ~q & q_nxt;
            q_fall   <= q & ~q_nxt;
            conflict <= conflict_evt | (conflict & ~conflict_clr);
        end
    end

endmodule

// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - bank of set/reset status bits with saturating conflict counter
module sr_reg_bank
    import sr_reg_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [WIDTH-1:0] conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic [WIDTH-1:0] conflict_evt;
    logic             any_evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (en),
            .mode         (mode),
            .set          (set[i]),
            .clr          (clr[i]),
            .ld           (ld),
            .ld_data      (ld_data[i]),
            .conflict_clr (conflict_clr[i]),
            .q            (q[i]),
            .q_rise       (q_rise[i]),
            .q_fall       (q_fall[i]),
            .conflict     (conflict[i]),
            .conflict_evt (conflict_evt[i])
        );
    end

    assign any_evt = |conflict_evt;

    // One count per cycle regardless of how many channels conflict; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (any_evt && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb/tb_sr_reg_bank.sv - randomized self-checking bench for sr_reg_bank
module tb_sr_reg_bank;

    localparam logic [7:0] RV = 8'h00;

    logic       clk = 1'b0;
    logic       rst, en, ld;
    logic [1:0] mode;
    logic [7:0] set, clr, ld_data, cclr;
    logic [7:0] q, q_rise, q_fall, conflict, cnt;
    logic [7:0] q2, q_rise2, q_fall2, conflict2;
    logic [1:0] cnt2;

    logic [7:0] m_q, m_rise, m_fall, m_conf;
    int         m_cnt, m_cnt2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    sr_reg_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .set(set), .clr(clr),
        .ld(ld), .ld_data(ld_data), .conflict_clr(cclr),
        .q(q), .q_rise(q_rise), .q_fall(q_fall), .conflict(conflict), .conflict_cnt(cnt)
    );

    sr_reg_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(RV)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .set(set), .clr(clr),
        .ld(ld), .ld_data(ld_data), .conflict_clr(cclr),
        .q(q2), .q_rise(q_rise2), .q_fall(q_fall2), .conflict(conflict2), .conflict_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: applies the behavioural rules to the current inputs, bit by bit.
    task automatic model_update();
        logic [7:0] nq, evt;
        if (rst) begin
            m_q = RV; m_rise = '0; m_fall = '0; m_conf = '0; m_cnt = 0; m_cnt2 = 0;
            return;
        end
        nq  = m_q;
        evt = '0;
        if (ld) begin
            nq = ld_data;
        end else if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (set[i] && !clr[i])      nq[i] = 1'b1;
                else if (!set[i] && clr[i]) nq[i] = 1'b0;
                else if (set[i] && clr[i]) begin
                    evt[i] = 1'b1;
                    if (mode == 2'd1)      nq[i] = 1'b1;
                    else if (mode == 2'd2) nq[i] = 1'b0;
                    else if (mode == 2'd3) nq[i] = !m_q[i];
                end
            end
        end
        m_conf = evt | (m_conf & ~cclr);
        m_rise = ~m_q & nq;
        m_fall = m_q & ~nq;
        m_q    = nq;
        if (evt != 0) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3)  m_cnt2++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("q",        32'(q),        32'(m_q));
        check("q_rise",   32'(q_rise),   32'(m_rise));
        check("q_fall",   32'(q_fall),   32'(m_fall));
        check("conflict", 32'(conflict), 32'(m_conf));
        check("cnt",      32'(cnt),      32'(m_cnt));
        check("cnt2",     32'(cnt2),     32'(m_cnt2));
        check("q2",       32'(q2),       32'(m_q));
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic [1:0] md,
                         input logic [7:0] s, input logic [7:0] c, input logic [7:0] d,
                         input logic [7:0] cc);
        rst = r; en = e; ld = l; mode = md; set = s; clr = c; ld_data = d; cclr = cc;
    endtask

    initial begin
        m_q = RV; m_rise = '0; m_fall = '0; m_conf = '0; m_cnt = 0; m_cnt2 = 0;
        drive(1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        cycle();
        check("reset_q", 32'(q), 32'(RV));
        check("reset_cnt", 32'(cnt), 32'd0);

        // set from reset
        drive(0, 1, 0, 2'd0, 8'h0F, 8'h00, 8'h00, 8'h00);
        cycle();
        check("t1_q", 32'(q), 32'h0F);
        check("t1_rise", 32'(q_rise), 32'h0F);
        drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        cycle();
        check("t1_rise_gone", 32'(q_rise), 32'h00);

        // each conflict policy
        drive(0, 1, 0, 2'd0, 8'h03, 8'h03, 8'h00, 8'h00); cycle(); check("t2_hold", 32'(q), 32'h0F);
        mode = 2'd1; cycle(); check("t2_setdom", 32'(q), 32'h0F);
        mode = 2'd2; cycle(); check("t2_rstdom", 32'(q), 32'h0C);
        drive(0, 1, 0, 2'd0, 8'h0F, 8'h00, 8'h00, 8'h00); cycle();
        drive(0, 1, 0, 2'd3, 8'h03, 8'h03, 8'h00, 8'h00); cycle(); check("t2_tog1", 32'(q), 32'h0C);
        cycle(); check("t2_tog2", 32'(q), 32'h0F);
        check("t2_conf", 32'(conflict), 32'h03);
        check("t2_cnt", 32'(cnt), 32'd5);

        // load beats set/clr and records no conflict
        drive(0, 1, 1, 2'd3, 8'hFF, 8'hFF, 8'hA5, 8'h00); cycle();
        check("t3_q", 32'(q), 32'hA5);
        check("t3_cnt", 32'(cnt), 32'd5);

        // new conflict wins over same-edge clear
        drive(0, 1, 0, 2'd0, 8'h01, 8'h01, 8'h00, 8'h01); cycle();
        check("t4_keep", 32'(conflict), 32'h03);
        drive(0, 1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h01); cycle();
        check("t4_clear", 32'(conflict), 32'h02);

        // 2-bit counter saturation
        drive(1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00); cycle();
        drive(0, 1, 0, 2'd0, 8'h81, 8'h81, 8'h00, 8'h00);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t5_cnt2", 32'(cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
        end

        // reset beats load; disabled path holds
        drive(0, 1, 1, 2'd0, 8'h00, 8'h00, 8'h3C, 8'h00); cycle();
        drive(1, 1, 1, 2'd0, 8'h00, 8'h00, 8'hFF, 8'h00); cycle();
        check("t6_q", 32'(q), 32'(RV));
        check("t6_fall", 32'(q_fall), 32'h00);
        check("t6_cnt", 32'(cnt), 32'd0);
        drive(0, 0, 0, 2'd1, 8'hFF, 8'h00, 8'h00, 8'h00); cycle();
        check("t6_hold", 32'(q), 32'(RV));

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
